// File: rtl/wash_phase_timer_if.sv
// rtl/wash_phase_timer_if.sv - controller-to-phase-timer signal bundle
interface wash_phase_timer_if #(
    parameter int SEC_W = 10
);
    logic             start;
    logic [2:0]       phase;
    logic [1:0]       freq_sel;
    logic             pause;
    logic             abort;
    logic             busy;
    logic             paused;
    logic             done;
    logic             cfg_err;
    logic [2:0]       cur_phase;
    logic [SEC_W-1:0] remaining_s;

    modport master (
        output start, phase, freq_sel, pause, abort,
        input  busy, paused, done, cfg_err, cur_phase, remaining_s
    );

    modport slave (
        input  start, phase, freq_sel, pause, abort,
        output busy, paused, done, cfg_err, cur_phase, remaining_s
    );
endinterface

// File: rtl/wash_phase_timer.sv
// rtl/wash_phase_timer.sv - per-phase seconds countdown with frequency-scaled prescaler
module wash_phase_timer #(
    parameter int BASE_CYCLES = 1000000,
    parameter int PRE_W       = 24,
    parameter int SEC_W       = 10,
    parameter int FILL_S      = 120,
    parameter int WASH_S      = 300,
    parameter int RINSE_S     = 120,
    parameter int SPIN_S      = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wash_phase_timer_if.slave    bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;

    if (((BASE_CYCLES * 8 - 1) >> PRE_W) != 0) begin : g_pre_chk
        $error("wash_phase_timer: PRE_W too narrow for BASE_CYCLES*8-1");
    end
    if (((FILL_S >> SEC_W) != 0) || ((WASH_S >> SEC_W) != 0) ||
        ((RINSE_S >> SEC_W) != 0) || ((SPIN_S >> SEC_W) != 0)) begin : g_dur_chk
        $error("wash_phase_timer: a phase duration does not fit in SEC_W");
    end

    logic [1:0]       state_q;
    logic [1:0]       fsel_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] period_m1;
    logic [SEC_W-1:0] rem_q;
    logic [2:0]       cur_q;
    logic             done_q;
    logic             cfg_err_q;
    logic [SEC_W-1:0] dur;
    logic             dur_valid;

    // Period doubles per frequency step, so the compare scales without a lookup table.
    assign period_m1 = (PRE_W'(BASE_CYCLES) << fsel_q) - PRE_W'(1);

    always_comb begin
        dur       = '0;
        dur_valid = 1'b1;
        case (bus.phase)
            3'b001:  dur = SEC_W'(FILL_S);
            3'b010:  dur = SEC_W'(WASH_S);
            3'b011:  dur = SEC_W'(RINSE_S);
            3'b100:  dur = SEC_W'(SPIN_S);
            default: dur_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            fsel_q    <= 2'd0;
            pre_q     <= '0;
            rem_q     <= '0;
            cur_q     <= 3'd0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (bus.start) begin
                    if (!dur_valid) begin
                        cfg_err_q <= 1'b1;
                    end else if (dur == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                        rem_q   <= dur;
                        cur_q   <= bus.phase;
                        fsel_q  <= bus.freq_sel;
                        pre_q   <= '0;
                    end
                end
            end else if (bus.abort) begin
                state_q <= S_IDLE;
                rem_q   <= '0;
                cur_q   <= 3'd0;
                pre_q   <= '0;
            end else if (bus.pause) begin
                state_q <= S_PAUSED;
            end else begin
                // Leaving PAUSED counts on the same edge, so only paused edges are lost.
                state_q <= S_RUN;
                if (pre_q == period_m1) begin
                    pre_q <= '0;
                    rem_q <= rem_q - SEC_W'(1);
                    if (rem_q == SEC_W'(1)) begin
                        state_q <= S_IDLE;
                        cur_q   <= 3'd0;
                        done_q  <= 1'b1;
                    end
                end else begin
                    pre_q <= pre_q + PRE_W'(1);
                end
            end
        end
    end

    assign bus.busy        = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign bus.paused      = (state_q == S_PAUSED);
    assign bus.done        = done_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.cur_phase   = cur_q;
    assign bus.remaining_s = rem_q;
endmodule
